// File: rtl/seq_mul_unit.sv
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH shift-add multiplier (mult/multu) behind a start/ready handshake.
// Optional macro SEQ_MUL_RADIX4_EN retires two multiplier bits per cycle instead of one.
module seq_mul_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mul_signed,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

`ifdef SEQ_MUL_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - STEP);

  typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0]   mcand, mcand_n;
  logic [WIDTH-1:0]   mplier, mplier_n;
  logic               neg, neg_n;
  logic [2*WIDTH-1:0] result_n;
  logic               ready_n;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] mcand_ext, addend0, acc_sum;

  // Operands are multiplied as magnitudes; the sign is reapplied once at the end.
  assign mag_a = (mul_signed && ina[WIDTH-1]) ? -ina : ina;
  assign mag_b = (mul_signed && inb[WIDTH-1]) ? -inb : inb;

  assign mcand_ext = {{WIDTH{1'b0}}, mcand};
  assign addend0   = mplier[0] ? (mcand_ext << cnt) : '0;

`ifdef SEQ_MUL_RADIX4_EN
  logic [2*WIDTH-1:0] addend1;
  assign addend1 = mplier[1] ? (mcand_ext << (cnt + CNT_W'(1))) : '0;
  assign acc_sum = acc + addend0 + addend1;
`else
  assign acc_sum = acc + addend0;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    neg_n    = neg;
    result_n = result_o;
    ready_n  = ready_o;
    case (state)
      IDLE: begin
        ready_n = 1'b0;
        if (start_i && !annul_i) begin
          if (ina == '0 || inb == '0) begin
            state_n = ZERO;
          end else begin
            state_n  = ON;
            mcand_n  = mag_a;
            mplier_n = mag_b;
            neg_n    = mul_signed & (ina[WIDTH-1] ^ inb[WIDTH-1]);
            acc_n    = '0;
            cnt_n    = '0;
          end
        end
      end
      ZERO: begin
        result_n = '0;
        ready_n  = 1'b1;
        state_n  = END;
      end
      ON: begin
        // Annul wins over progress and leaves the previous result untouched.
        if (annul_i) begin
          state_n = IDLE;
          ready_n = 1'b0;
        end else begin
          acc_n    = acc_sum;
          mplier_n = mplier >> STEP;
          cnt_n    = cnt + CNT_W'(STEP);
          if (cnt == LAST_CNT) begin
            result_n = neg ? -acc_sum : acc_sum;
            ready_n  = 1'b1;
            state_n  = END;
          end
        end
      end
      END: begin
        ready_n = 1'b1;
        if (!start_i) begin
          state_n  = IDLE;
          ready_n  = 1'b0;
          result_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      acc      <= acc_n;
      mcand    <= mcand_n;
      mplier   <= mplier_n;
      neg      <= neg_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Scoreboard bench for seq_mul_unit: the driver queues expected products and latencies, a monitor checks each ready_o rise.
// Honors SEQ_MUL_RADIX4_EN for the expected ON latency.
module tb_seq_mul_unit;

`ifdef SEQ_MUL_RADIX4_EN
  localparam int ON_LAT = 16;
`else
  localparam int ON_LAT = 32;
`endif

  logic        clk;
  logic        resetn;
  logic        mul_signed;
  logic [31:0] ina;
  logic [31:0] inb;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_ready = 1'b0;

  typedef struct {
    logic [63:0] result;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  seq_mul_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mul_signed (mul_signed),
    .ina        (ina),
    .inb        (inb),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Latency is counted from the edge that sampled start to the edge that raised ready_o.
  always @(negedge clk) begin
    if (resetn && ready_o && !prev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_ready: actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("result", result_o, mon_e.result);
        checkOutput("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
      end
    end
    prev_ready = ready_o;
  end

  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp_res, input int exp_lat, input int hold,
                               input string name);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    @(negedge clk);
    mul_signed = sgn;
    ina        = a;
    inb        = b;
    start_i    = 1'b1;
    e.result    = exp_res;
    e.start_cyc = cyc + 1;
    e.lat       = exp_lat;
    exp_q.push_back(e);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      // Operands are scrambled after sampling; the unit must ignore them.
      if (i == 0) begin
        ina        = $urandom;
        inb        = $urandom;
        mul_signed = ~sgn;
      end
      if (ready_o) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: ready_o=0 after 100 cycles, required 1", name);
      exp_q.delete();
      start_i = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({name, "_hold_ready"}, 64'(ready_o), 64'd1);
      checkOutput({name, "_hold_result"}, result_o, exp_res);
    end
    start_i = 1'b0;
    @(negedge clk);
    checkOutput({name, "_drop_ready"}, 64'(ready_o), 64'd0);
    checkOutput({name, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    exp_t e;
    bit   seen;
    resetn     = 1'b1;
    start_i    = 1'b0;
    annul_i    = 1'b0;
    mul_signed = 1'b0;
    ina        = '0;
    inb        = '0;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 64'(ready_o), 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 64'(ready_o), 64'd0);

    applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, ON_LAT, 5, "umax");
    applyStimulus(1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, ON_LAT, 1, "smix");
    applyStimulus(1'b0, 32'hFFFFFFFD, 32'h00000007, 64'h00000006_FFFFFFEB, ON_LAT, 1, "umix");
    applyStimulus(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, ON_LAT, 0, "scorner");
    applyStimulus(1'b0, 32'h00000000, 32'h00001234, 64'h0, 1, 2, "zero_a");
    applyStimulus(1'b1, 32'h00008765, 32'h00000000, 64'h0, 1, 0, "zero_b");
    applyStimulus(1'b1, 32'hFFFFFFFE, 32'hFFFFFFFD, 64'h00000000_00000006, ON_LAT, 0, "sneg_neg");
    applyStimulus(1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, ON_LAT, 0, "smax_min");

    // Annul on the tenth ON edge: no result may ever appear.
    @(negedge clk);
    mul_signed = 1'b0;
    ina        = 32'h12345678;
    inb        = 32'h00000003;
    start_i    = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    checkOutput("annul_ready", 64'(ready_o), 64'd0);
    repeat (40) @(negedge clk);
    checkOutput("annul_no_ready", 64'(ready_o), 64'd0);
    applyStimulus(1'b0, 32'd5, 32'd6, 64'd30, ON_LAT, 0, "after_annul");

    // Reset between edges while ON.
    @(negedge clk);
    mul_signed = 1'b0;
    ina        = 32'hFFFFFFFF;
    inb        = 32'hFFFFFFFF;
    start_i    = 1'b1;
    repeat (6) @(negedge clk);
    #2 resetn = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("rst_on_ready", 64'(ready_o), 64'd0);
    checkOutput("rst_on_result", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("rst_on_no_ready", 64'(ready_o), 64'd0);

    // Reset between edges while END holds a nonzero product.
    @(negedge clk);
    mul_signed = 1'b0;
    ina        = 32'd3;
    inb        = 32'd5;
    start_i    = 1'b1;
    e.result    = 64'd15;
    e.start_cyc = cyc + 1;
    e.lat       = ON_LAT;
    exp_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL rst_end_timeout: ready_o=0 after 100 cycles, required 1");
      exp_q.delete();
    end
    #2 resetn = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("rst_end_ready", 64'(ready_o), 64'd0);
    checkOutput("rst_end_result", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    applyStimulus(1'b1, 32'd6, 32'hFFFFFFF9, 64'hFFFFFFFF_FFFFFFD6, ON_LAT, 0, "after_reset");

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL pending_results: actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
